// File: rtl/status_flag_ctrl.sv
// NZCV status register with flag-hazard tracking between ID issue and EXE commit.
// Optional EXE-to-ID flag bypass enabled by defining FLAG_FWD_EN.
module status_flag_ctrl #(
  parameter int PEND_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       id_set_s,
  input  logic       exe_flag_we,
  input  logic [3:0] exe_flags,
  input  logic       flush,
  output logic       stall,
  output logic       issue,
  output logic       cond_pass,
  output logic [3:0] status,
  output logic       seq_err
);

  localparam logic [PEND_DEPTH-1:0] TOP =
    PEND_DEPTH'(1) << (PEND_DEPTH - 1);

  logic [PEND_DEPTH-1:0] pipe;
  logic [PEND_DEPTH-1:0] pipe_n;
  logic [PEND_DEPTH-1:0] haz_bits;
  logic [3:0]            flags;
  logic                  fwd;
  logic                  is_cond;
  logic                  hazard;
  logic                  pass;
  logic                  n, z, c, v;

  assign is_cond = id_cond != 4'b1110;

`ifdef FLAG_FWD_EN
  // EXE setter is the only one in flight: take its flags directly.
  assign fwd = exe_flag_we & ~|(pipe & ~TOP);
`else
  assign fwd = 1'b0;
`endif

  assign haz_bits = fwd ? (pipe & ~TOP) : pipe;
  assign hazard   = id_valid & is_cond & (|haz_bits);
  assign stall    = hazard;
  assign issue    = id_valid & ~hazard & ~flush;

  assign flags = fwd ? exe_flags : status;
  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  always_comb begin
    pass = 1'b1;
    case (id_cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = n == v;
      4'b1011: pass = n != v;
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

  assign cond_pass = issue & pass;

  // A flush kills every younger setter, so nothing shifts toward EXE.
  always_comb begin
    pipe_n    = '0;
    pipe_n[0] = ~flush & cond_pass & id_set_s;
    for (int i = 1; i < PEND_DEPTH; i++)
      pipe_n[i] = ~flush & pipe[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe    <= '0;
      status  <= '0;
      seq_err <= 1'b0;
    end else begin
      pipe <= pipe_n;
      if (exe_flag_we)
        status <= exe_flags;
      if (exe_flag_we != pipe[PEND_DEPTH-1])
        seq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_status_flag_ctrl.sv
// Directed self-checking bench for status_flag_ctrl (PEND_DEPTH=2).
// Handles both the default build and a FLAG_FWD_EN build.
module tb_status_flag_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_cond;
  logic       id_set_s;
  logic       exe_flag_we;
  logic [3:0] exe_flags;
  logic       flush;
  logic       stall;
  logic       issue;
  logic       cond_pass;
  logic [3:0] status;
  logic       seq_err;

  int checks = 0;
  int errors = 0;

  status_flag_ctrl #(.PEND_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_cond     (id_cond),
    .id_set_s    (id_set_s),
    .exe_flag_we (exe_flag_we),
    .exe_flags   (exe_flags),
    .flush       (flush),
    .stall       (stall),
    .issue       (issue),
    .cond_pass   (cond_pass),
    .status      (status),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [3:0] cnd,
                       input logic s);
    id_valid = vld;
    id_cond  = cnd;
    id_set_s = s;
    #2;
  endtask

  // Out-of-band committed flag value via a tracked setter.
  task automatic load_flags(input logic [3:0] f);
    drive(1'b1, 4'b1110, 1'b1);
    tick();
    drive(1'b0, 4'b1110, 1'b0);
    tick();
    exe_flag_we = 1'b1;
    exe_flags   = f;
    tick();
    exe_flag_we = 1'b0;
  endtask

  task automatic cond_row(input string tag, input logic [3:0] cnd,
                          input logic exp);
    drive(1'b1, cnd, 1'b0);
    check({tag, "_iss"}, 8'(issue), 8'd1);
    check(tag, 8'(cond_pass), 8'(exp));
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 0; id_cond = 4'b1110; id_set_s = 0;
    exe_flag_we = 0; exe_flags = 0; flush = 0;
    tick();
    tick();
    rst = 1'b0;

    drive(1'b1, 4'b1110, 1'b0);
    check("rst_status", 8'(status), 8'h0);
    check("rst_seq", 8'(seq_err), 8'd0);
    check("rst_stall", 8'(stall), 8'd0);
    check("al_issue", 8'(issue), 8'd1);
    check("al_pass", 8'(cond_pass), 8'd1);
    tick();

    // setter then BEQ
    drive(1'b1, 4'b1110, 1'b1);
    check("set_issue", 8'(issue), 8'd1);
    tick();
    drive(1'b1, 4'b0000, 1'b0);
    check("beq_c1_stall", 8'(stall), 8'd1);
    check("beq_c1_issue", 8'(issue), 8'd0);
    check("beq_c1_pass", 8'(cond_pass), 8'd0);
    tick();
    exe_flag_we = 1'b1;
    exe_flags   = 4'b0100;
    #2;
`ifdef FLAG_FWD_EN
    check("beq_c2_stall", 8'(stall), 8'd0);
    check("beq_c2_issue", 8'(issue), 8'd1);
    check("beq_c2_pass", 8'(cond_pass), 8'd1);
`else
    check("beq_c2_stall", 8'(stall), 8'd1);
    check("beq_c2_issue", 8'(issue), 8'd0);
`endif
    tick();
    exe_flag_we = 1'b0;
    drive(1'b1, 4'b0000, 1'b0);
    check("c3_status", 8'(status), 8'h4);
    check("c3_seq", 8'(seq_err), 8'd0);
    check("c3_stall", 8'(stall), 8'd0);
    check("c3_issue", 8'(issue), 8'd1);
    check("c3_pass", 8'(cond_pass), 8'd1);
    tick();

    // failed-condition setter is not tracked
    drive(1'b1, 4'b0001, 1'b1);
    check("ne_set_issue", 8'(issue), 8'd1);
    check("ne_set_pass", 8'(cond_pass), 8'd0);
    tick();
    drive(1'b1, 4'b0000, 1'b0);
    check("ne_next_stall", 8'(stall), 8'd0);
    check("ne_next_pass", 8'(cond_pass), 8'd1);
    tick();

    // flush kills an in-flight setter
    drive(1'b1, 4'b1110, 1'b1);
    tick();
    flush = 1'b1;
    drive(1'b1, 4'b0000, 1'b0);
    check("fl_stall", 8'(stall), 8'd1);
    check("fl_issue", 8'(issue), 8'd0);
    tick();
    flush = 1'b0;
    drive(1'b1, 4'b0000, 1'b0);
    check("fl_after_stall", 8'(stall), 8'd0);
    check("fl_after_pass", 8'(cond_pass), 8'd1);
    tick();
    drive(1'b0, 4'b1110, 1'b0);
    tick();
    check("fl_seq", 8'(seq_err), 8'd0);
    check("fl_status", 8'(status), 8'h4);

    // N=1 V=1 decodes
    load_flags(4'b1001);
    #1;
    check("nv_status", 8'(status), 8'h9);
    cond_row("gt", 4'b1100, 1'b1);
    cond_row("lt", 4'b1011, 1'b0);
    cond_row("ge", 4'b1010, 1'b1);
    cond_row("mi", 4'b0100, 1'b1);
    cond_row("vs", 4'b0110, 1'b1);
    cond_row("eq0", 4'b0000, 1'b0);
    cond_row("hi", 4'b1000, 1'b0);
    cond_row("ls_nc", 4'b1001, 1'b1);
    tick();

    // Z=1 decodes
    load_flags(4'b0100);
    cond_row("ls_z", 4'b1001, 1'b1);
    cond_row("le_z", 4'b1101, 1'b1);
    cond_row("gt_z", 4'b1100, 1'b0);
    cond_row("cs_z", 4'b0010, 1'b0);
    cond_row("vc_z", 4'b0111, 1'b1);
    check("zc_seq", 8'(seq_err), 8'd0);
    tick();

    // reset mid-stall
    drive(1'b1, 4'b1110, 1'b1);
    tick();
    drive(1'b1, 4'b0000, 1'b0);
    check("ms_stall", 8'(stall), 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 4'b0000, 1'b0);
    check("ms_rst_stall", 8'(stall), 8'd0);
    check("ms_rst_status", 8'(status), 8'h0);
    tick();

    // unexpected commit
    drive(1'b0, 4'b1110, 1'b0);
    exe_flag_we = 1'b1;
    exe_flags   = 4'b0010;
    tick();
    exe_flag_we = 1'b0;
    #2;
    check("se_set", 8'(seq_err), 8'd1);
    check("se_status", 8'(status), 8'h2);
    tick();
    tick();
    check("se_sticky", 8'(seq_err), 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    check("se_clr", 8'(seq_err), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
